// File: rtl/ip_sram_pkg.sv
// Shared definitions for the SRAM access sequencer: bus widths, default
// strobe length and the 2-bit state encoding.
package ip_sram_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  // Default access strobe length in clk cycles (legal range 1..15).
  localparam logic [CNT_W-1:0] WAIT_CYCLES_DEFAULT = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RECOVER = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ip_sram_sequencer.sv
// SRAM access sequencer: turns level rd/wr requests from the mapper RAM
// interface into fixed-length asynchronous SRAM read/write cycles, with a
// one-deep pending slot so a request arriving mid-access is not lost.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no access; strobes high, data bus released
// ST_READ    | CE/OE low for WAIT_CYCLES clocks, data sampled on last one
// ST_WRITE   | CE/WE low for WAIT_CYCLES clocks, data bus driven
// ST_RECOVER | one clock strobes high; bus still driven after a write
module ip_sram_sequencer
  import ip_sram_pkg::*;
#(
  parameter logic [CNT_W-1:0] WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              rd,
  input  logic              wr,
  output logic              busy,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_en,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d_o,
  output logic              sram_d_oe,
  input  logic [DATA_W-1:0] sram_d_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;

  logic              rd_q;
  logic              wr_q;
  logic              rd_rise;
  logic              wr_rise;
  logic              start;

  logic              pend_valid;
  logic              pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;

  logic              launch;
  logic              take_pend;
  logic              launch_wr;
  logic [ADDR_W-1:0] launch_addr;
  logic [DATA_W-1:0] launch_wdata;

  // Requests are edges, not levels; a held rd/wr issues only one access.
  // Write wins when both rise together, the read is simply not seen.
  assign rd_rise = rd & ~rd_q;
  assign wr_rise = wr & ~wr_q;
  assign start   = rd_rise | wr_rise;

  assign busy = (state != ST_IDLE) | pend_valid;

  // Edge history; cleared in reset so a level already high at release
  // counts as a fresh request on the first clock.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
    end
  end

  // Pick what the next access would be: the pending slot has precedence in
  // RECOVER, otherwise a request detected this edge starts directly.
  always_comb begin
    launch       = 1'b0;
    take_pend    = 1'b0;
    launch_wr    = wr_rise;
    launch_addr  = address;
    launch_wdata = wdata;
    case (state)
      ST_IDLE: begin
        launch = start;
      end
      ST_RECOVER: begin
        if (pend_valid) begin
          launch       = 1'b1;
          take_pend    = 1'b1;
          launch_wr    = pend_wr;
          launch_addr  = pend_addr;
          launch_wdata = pend_wdata;
        end else begin
          launch = start;
        end
      end
      default: begin
        launch = 1'b0;
      end
    endcase
  end

  // One-deep pending slot; a request arriving while it is full is dropped.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
    end else if (take_pend) begin
      pend_valid <= 1'b0;
    end else if (start && !pend_valid &&
                 (state == ST_READ || state == ST_WRITE)) begin
      pend_valid <= 1'b1;
      pend_wr    <= wr_rise;
      pend_addr  <= address;
      pend_wdata <= wdata;
    end
  end

  // Access FSM with registered SRAM strobes, bus control and read data.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sram_a    <= '0;
      sram_d_o  <= '0;
      sram_d_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      rdata     <= '0;
      rdata_en  <= 1'b0;
    end else begin
      rdata_en <= 1'b0;
      case (state)
        ST_IDLE, ST_RECOVER: begin
          if (launch) begin
            state     <= launch_wr ? ST_WRITE : ST_READ;
            cnt       <= WAIT_CYCLES - 4'd1;
            sram_a    <= launch_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= launch_wr;
            sram_we_n <= ~launch_wr;
            sram_d_oe <= launch_wr;
            if (launch_wr) begin
              sram_d_o <= launch_wdata;
            end
          end else begin
            // Address and write data keep their last values in idle.
            state     <= ST_IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_d_oe <= 1'b0;
          end
        end
        ST_READ: begin
          if (cnt == '0) begin
            state     <= ST_RECOVER;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            rdata     <= sram_d_i;
            rdata_en  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WRITE: begin
          if (cnt == '0) begin
            // Keep driving the bus one more clock for data hold time.
            state     <= ST_RECOVER;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ip_sram_sequencer.sv
// Self-checking bench for ip_sram_sequencer. Expected accesses are queued
// as stimulus is driven and checked by a monitor when the SRAM strobes show
// each access.
module tb_ip_sram_sequencer;
  import ip_sram_pkg::*;

  localparam int WC = 3;

  logic        clk;
  logic        n_reset;
  logic        rd;
  logic        wr;
  logic        busy;
  logic [21:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_en;
  logic [21:0] sram_a;
  logic [7:0]  sram_d_o;
  logic        sram_d_oe;
  logic [7:0]  rd_val;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int n_tests = 0;
  int n_fail  = 0;
  int reads_done = 0;

  typedef struct packed {
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  data;
  } acc_t;

  acc_t exp_q[$];

  ip_sram_sequencer #(.WAIT_CYCLES(4'd3)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .rd        (rd),
    .wr        (wr),
    .busy      (busy),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdata_en  (rdata_en),
    .sram_a    (sram_a),
    .sram_d_o  (sram_d_o),
    .sram_d_oe (sram_d_oe),
    .sram_d_i  (rd_val),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic w, input logic [21:0] a, input logic [7:0] d);
    acc_t e;
    e.wr = w;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: pops an expected access at each strobe start.
  task automatic monitor();
    logic prev_ce_n = 1'b1;
    int   low_cnt = 0;
    acc_t cur = '0;
    logic rd_end;
    forever begin
      @(negedge clk);
      if (n_reset !== 1'b1) begin
        prev_ce_n = 1'b1;
        low_cnt = 0;
        continue;
      end
      rd_end = 1'b0;
      if (sram_ce_n === 1'b0) begin
        if (prev_ce_n === 1'b1) begin
          low_cnt = 0;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_access: a=%h we_n=%b, none expected", sram_a, sram_we_n);
            cur = '0;
            cur.wr = ~sram_we_n;
            cur.addr = sram_a;
          end else begin
            cur = exp_q.pop_front();
            n_tests++;
            if ({sram_we_n, sram_oe_n, sram_d_oe} !== (cur.wr ? 3'b011 : 3'b100)) begin
              n_fail++;
              $display("FAIL acc_dir: we/oe/doe=%b%b%b want wr=%b", sram_we_n, sram_oe_n, sram_d_oe, cur.wr);
            end
            n_tests++;
            if (sram_a !== cur.addr) begin
              n_fail++;
              $display("FAIL acc_addr: got %h want %h", sram_a, cur.addr);
            end
            if (cur.wr) begin
              n_tests++;
              if (sram_d_o !== cur.data) begin
                n_fail++;
                $display("FAIL acc_wdata: got %h want %h", sram_d_o, cur.data);
              end
            end
          end
        end
        low_cnt++;
      end else if (prev_ce_n === 1'b0) begin
        n_tests++;
        if (low_cnt != WC) begin
          n_fail++;
          $display("FAIL strobe_len: got %0d want %0d", low_cnt, WC);
        end
        if (!cur.wr) begin
          rd_end = 1'b1;
          reads_done++;
          n_tests++;
          if (rdata_en !== 1'b1 || rdata !== cur.data) begin
            n_fail++;
            $display("FAIL read_data: en=%b rdata=%h want en=1 rdata=%h", rdata_en, rdata, cur.data);
          end
        end
      end
      if (!rd_end) begin
        n_tests++;
        if (rdata_en !== 1'b0) begin
          n_fail++;
          $display("FAIL spurious_rdata_en: got %b want 0", rdata_en);
        end
      end
      prev_ce_n = sram_ce_n;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_access: %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    address = '0;
    wdata = '0;
    rd_val = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b%b%b%b want 1110", sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe);
    end
    n_tests++;
    if (sram_a !== 22'h0 || sram_d_o !== 8'h0 || rdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data: a=%h d_o=%h rdata=%h want 0", sram_a, sram_d_o, rdata);
    end
    n_tests++;
    if (rdata_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rdata_en=%b busy=%b want 0 0", rdata_en, busy);
    end
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    address = 22'h012345;
    rd_val = 8'hA5;
    push_exp(1'b0, 22'h012345, 8'hA5);
    rd = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (sram_oe_n !== ((k <= WC) ? 1'b0 : 1'b1) || sram_we_n !== 1'b1) begin
        n_fail++;
        $display("FAIL read_oe_k%0d: oe_n=%b we_n=%b want %b 1", k, sram_oe_n, sram_we_n, (k <= WC) ? 1'b0 : 1'b1);
      end
      n_tests++;
      if (rdata_en !== ((k == WC + 1) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL read_en_k%0d: got %b want %b", k, rdata_en, (k == WC + 1));
      end
      if (k == 1) address = 22'h000000;
      if (k == 2) begin
        n_tests++;
        if (sram_a !== 22'h012345) begin
          n_fail++;
          $display("FAIL read_addr_latched: got %h want 012345", sram_a);
        end
      end
    end
    n_tests++;
    if (rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_rdata: got %h want a5", rdata);
    end
    rd = 1'b0;
    wait_idle();
  endtask

  task automatic test_write();
    address = 22'h3FFFFF;
    wdata = 8'h5A;
    push_exp(1'b1, 22'h3FFFFF, 8'h5A);
    wr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (sram_we_n !== ((k <= WC) ? 1'b0 : 1'b1) || sram_oe_n !== 1'b1) begin
        n_fail++;
        $display("FAIL write_we_k%0d: we_n=%b oe_n=%b", k, sram_we_n, sram_oe_n);
      end
      n_tests++;
      if (sram_d_oe !== ((k <= WC + 1) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL write_doe_k%0d: got %b want %b", k, sram_d_oe, (k <= WC + 1));
      end
      if (k == 1) wdata = 8'h00;
      if (k == 4) begin
        n_tests++;
        if (sram_d_o !== 8'h5A || sram_a !== 22'h3FFFFF) begin
          n_fail++;
          $display("FAIL write_hold: d_o=%h a=%h want 5a 3fffff", sram_d_o, sram_a);
        end
      end
    end
    n_tests++;
    if (rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_rdata_held: got %h want a5", rdata);
    end
    wr = 1'b0;
    wait_idle();
  endtask

  task automatic test_held_rd();
    int r0;
    r0 = reads_done;
    address = 22'h00ABCD;
    rd_val = 8'h3C;
    push_exp(1'b0, 22'h00ABCD, 8'h3C);
    rd = 1'b1;
    repeat (20) @(negedge clk);
    rd = 1'b0;
    wait_idle();
    n_tests++;
    if (reads_done - r0 != 1) begin
      n_fail++;
      $display("FAIL held_rd_count: got %0d want 1", reads_done - r0);
    end
  endtask

  task automatic test_back_to_back();
    address = 22'h111111;
    wdata = 8'hC7;
    rd_val = 8'h96;
    push_exp(1'b1, 22'h111111, 8'hC7);
    push_exp(1'b0, 22'h222222, 8'h96);
    wr = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== ((k <= 8) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL b2b_busy_k%0d: got %b want %b", k, busy, (k <= 8));
      end
      if (k == 1) begin
        wr = 1'b0;
        rd = 1'b1;
        address = 22'h222222;
      end
      if (k == 2) begin
        rd = 1'b0;
        wr = 1'b1;
        address = 22'h333333;
        wdata = 8'hEE;
      end
    end
    wr = 1'b0;
    wait_idle();
  endtask

  task automatic test_simultaneous();
    address = 22'h0F0F0F;
    wdata = 8'h81;
    rd_val = 8'h42;
    push_exp(1'b1, 22'h0F0F0F, 8'h81);
    rd = 1'b1;
    wr = 1'b1;
    @(negedge clk);
    wait_idle();
    n_tests++;
    if (rdata !== 8'h96) begin
      n_fail++;
      $display("FAIL simul_rdata_held: got %h want 96", rdata);
    end
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    address = 22'h054321;
    rd_val = 8'h77;
    push_exp(1'b0, 22'h054321, 8'h77);
    rd = 1'b1;
    repeat (2) @(negedge clk);
    n_reset = 1'b0;
    #1;
    n_tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe} !== 4'b1110) begin
      n_fail++;
      $display("FAIL midrst_strobes: got %b%b%b%b want 1110", sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe);
    end
    n_tests++;
    if (rdata_en !== 1'b0 || busy !== 1'b0 || sram_a !== 22'h0 || rdata !== 8'h0) begin
      n_fail++;
      $display("FAIL midrst_state: en=%b busy=%b a=%h rdata=%h want 0 0 0 0", rdata_en, busy, sram_a, rdata);
    end
    rd = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: queued=%0d busy=%b want 0 0", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_rd_at_release();
    int r0;
    r0 = reads_done;
    n_reset = 1'b0;
    address = 22'h0155AA;
    rd_val = 8'hC3;
    rd = 1'b1;
    push_exp(1'b0, 22'h0155AA, 8'hC3);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL release_accept: busy=%b want 1", busy);
    end
    wait_idle();
    rd = 1'b0;
    n_tests++;
    if (reads_done - r0 != 1 || rdata !== 8'hC3) begin
      n_fail++;
      $display("FAIL release_read: reads=%0d rdata=%h want 1 c3", reads_done - r0, rdata);
    end
  endtask

  initial begin
    n_reset = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    address = '0;
    wdata = '0;
    rd_val = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_read();
    test_write();
    test_held_rd();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_read();
    test_rd_at_release();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
